// File: rtl/instr_mem_pipe.sv
// Instruction memory for the RV32I fetch stage: fixed-latency read pipeline
// with a response queue, fault flagging, flush and a run-time programming port.
module instr_mem_pipe #(
    parameter int          DEPTH     = 64,
    parameter int          READ_LAT  = 1,
    parameter string       INIT_FILE = "INSTRUCTION_MEM.mem",
    parameter logic [31:0] NOP       = 32'h00000013,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_pc,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_instr,
    output logic [31:0]   rsp_pc,
    output logic [1:0]    rsp_fault,
    input  logic          flush,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata
);

    localparam int QD = READ_LAT + 1;
    localparam int PW = $clog2(QD);
    localparam int CW = $clog2(QD + 1);

    logic [31:0] mem [0:DEPTH-1];

    logic [READ_LAT:1] st_v;
    logic [31:0]       st_pc  [1:READ_LAT];
    logic [31:0]       st_dat [1:READ_LAT];
    logic [1:0]        st_flt [1:READ_LAT];

    logic [31:0] q_pc  [0:QD-1];
    logic [31:0] q_dat [0:QD-1];
    logic [1:0]  q_flt [0:QD-1];

    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt, cred;

    logic        mis, oor, accept, pop, push, q_pop, q_empty;
    logic [31:0] rd_word;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (prog_we && 32'(prog_addr) < 32'(DEPTH))
            mem[prog_addr] <= prog_wdata;
    end

    assign mis = |req_pc[1:0];
    assign oor = req_pc[31:2] >= 30'(DEPTH);

    always_comb begin
        rd_word = NOP;
        if (!(mis | oor))
            rd_word = mem[req_pc[AW+1:2]];
    end

    // Last pipeline stage bypasses the queue when it is empty, so the
    // queue adds no latency; a stalled bypass entry is parked in the queue.
    assign q_empty   = (cnt == '0);
    assign rsp_valid = q_empty ? st_v[READ_LAT] : 1'b1;
    assign rsp_instr = q_empty ? st_dat[READ_LAT] : q_dat[rptr];
    assign rsp_pc    = q_empty ? st_pc[READ_LAT] : q_pc[rptr];
    assign rsp_fault = q_empty ? st_flt[READ_LAT] : q_flt[rptr];

    assign pop       = rsp_valid & rsp_ready;
    assign q_pop     = pop & !q_empty;
    assign push      = st_v[READ_LAT] & !(q_empty & rsp_ready);
    assign req_ready = !flush & ((cred < CW'(QD)) | pop);
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wptr]  <= st_pc[READ_LAT];
            q_dat[wptr] <= st_dat[READ_LAT];
            q_flt[wptr] <= st_flt[READ_LAT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_v <= '0;
            for (int k = 1; k <= READ_LAT; k++) begin
                st_pc[k]  <= '0;
                st_dat[k] <= NOP;
                st_flt[k] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            cred <= '0;
        end else begin
            st_pc[1]  <= req_pc;
            st_dat[1] <= rd_word;
            st_flt[1] <= {oor, mis};
            for (int k = 2; k <= READ_LAT; k++) begin
                st_pc[k]  <= st_pc[k-1];
                st_dat[k] <= st_dat[k-1];
                st_flt[k] <= st_flt[k-1];
            end
            if (flush) begin
                st_v <= '0;
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                cred <= '0;
            end else begin
                st_v[1] <= accept;
                for (int k = 2; k <= READ_LAT; k++)
                    st_v[k] <= st_v[k-1];
                if (push)
                    wptr <= inc(wptr);
                if (q_pop)
                    rptr <= inc(rptr);
                cnt  <= cnt + CW'(push) - CW'(q_pop);
                cred <= cred + CW'(accept) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Randomised and directed bench for instr_mem_pipe against a queue-based
// model of in-flight fetches, each tagged with the cycle it becomes visible.
module tb_instr_mem_pipe;

    localparam int          DEPTH = 12;
    localparam int          LAT   = 2;
    localparam int          QD    = LAT + 1;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic [1:0]  rsp_fault;
    logic        flush = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [31:0] prog_wdata = '0;

    instr_mem_pipe #(
        .DEPTH(DEPTH), .READ_LAT(LAT), .INIT_FILE(""), .NOP(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
        .flush(flush), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rdy;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [1:0]  flt;
    } ent_t;

    ent_t        mq [$];
    ent_t        lg [$];
    logic [31:0] mmem [DEPTH];
    int cyc = 0, total = 0, bad = 0, n_acc = 0, last_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input int rdy);
        ent_t e;
        e.rdy = rdy;
        e.pc  = pc;
        e.flt = {(pc >> 2) >= 32'(DEPTH), pc[1:0] != 2'b00};
        e.ins = NOP;
        if (e.flt == 2'b00)
            e.ins = mmem[pc >> 2];
        return e;
    endfunction

    // Called at a falling edge with inputs already driven.
    task automatic step();
        logic ev, ep, er;
        ent_t h;
        #1;
        ev = mq.size() > 0 && mq[0].rdy <= cyc;
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            h = mq[0];
            chk("rsp_instr", rsp_instr, h.ins);
            chk("rsp_pc", rsp_pc, h.pc);
            chk("rsp_fault", 32'(rsp_fault), 32'(h.flt));
        end
        ep = ev && rsp_ready;
        er = !flush && (mq.size() < QD || ep);
        chk("req_ready", 32'(req_ready), 32'(er));
        if (req_valid && req_ready) begin
            n_acc++;
            last_acc = cyc;
        end
        if (ep) begin
            h.rdy = cyc;
            lg.push_back(h);
            void'(mq.pop_front());
        end
        if (req_valid && er)
            mq.push_back(mk(req_pc, cyc + LAT));
        if (prog_we && 32'(prog_addr) < 32'(DEPTH))
            mmem[prog_addr] = prog_wdata;
        if (flush)
            mq.delete();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic fetch(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc = pc;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int n_stale;
        logic [31:0] fp [3];
        logic [1:0]  ff [3];
        fp[0] = 32'd6;  fp[1] = 32'd48; fp[2] = 32'd49;
        ff[0] = 2'b01;  ff[1] = 2'b10;  ff[2] = 2'b11;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_instr", rsp_instr, 32'h00000013);
        chk("reset_rsp_pc", rsp_pc, 32'd0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_out_of_reset", 32'(req_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) begin
            prog_we = 1'b1;
            prog_addr = 4'(i);
            prog_wdata = (i == 0) ? 32'h04000413 :
                         (i == 1) ? 32'h03200493 :
                         (i == 5) ? 32'h00500513 : $urandom;
            step();
        end
        prog_we = 1'b0;

        // back-to-back fetch at full rate
        rsp_ready = 1'b1;
        lg.delete();
        req_valid = 1'b1; req_pc = 32'd0; step();
        req_pc = 32'd4; step();
        idle(4);
        chk("seq_count", 32'(lg.size()), 32'd2);
        chk("seq0_instr", lg[0].ins, 32'h04000413);
        chk("seq0_pc", lg[0].pc, 32'd0);
        chk("seq1_instr", lg[1].ins, 32'h03200493);
        chk("seq1_pc", lg[1].pc, 32'd4);
        chk("seq_gap", 32'(lg[1].rdy - lg[0].rdy), 32'd1);

        // latency from accept to first response
        lg.delete();
        fetch(32'd8);
        t = last_acc;
        idle(4);
        chk("lat_count", 32'(lg.size()), 32'd1);
        chk("lat_cycles", 32'(lg[0].rdy - t), 32'd2);
        chk("lat_pc", lg[0].pc, 32'd8);

        // back-pressure: credits cap accepts at queue depth
        rsp_ready = 1'b0;
        n_acc = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_pc = 32'(12 + 4 * n_acc);
            step();
        end
        #1;
        chk("bp_accepts", 32'(n_acc), 32'd3);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        lg.delete();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        idle(5);
        chk("bp_drain_count", 32'(lg.size()), 32'd3);
        chk("bp_drain0", lg[0].pc, 32'd12);
        chk("bp_drain1", lg[1].pc, 32'd16);
        chk("bp_drain2", lg[2].pc, 32'd20);

        // fault encodings
        for (int i = 0; i < 3; i++) begin
            lg.delete();
            fetch(fp[i]);
            idle(4);
            chk("fault_count", 32'(lg.size()), 32'd1);
            chk("fault_instr", lg[0].ins, 32'h00000013);
            chk("fault_bits", 32'(lg[0].flt), 32'(ff[i]));
        end

        // flush with two fetches in flight
        rsp_ready = 1'b0;
        lg.delete();
        fetch(32'h10);
        fetch(32'h14);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        idle(4);
        n_stale = 0;
        foreach (lg[i])
            if (lg[i].pc == 32'h10 || lg[i].pc == 32'h14)
                n_stale++;
        chk("flush_no_stale", 32'(n_stale), 32'd0);
        fetch(32'd0);
        idle(4);
        chk("flush_refetch", lg[0].ins, 32'h04000413);

        // programming write racing a read of the same word
        lg.delete();
        req_valid = 1'b1; req_pc = 32'd20;
        prog_we = 1'b1; prog_addr = 4'd5; prog_wdata = 32'hDEADBEEF;
        step();
        prog_we = 1'b0;
        idle(3);
        fetch(32'd20);
        idle(4);
        chk("prog_old", lg[0].ins, 32'h00500513);
        chk("prog_new", lg[1].ins, 32'hDEADBEEF);

        // async reset with a full queue
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_pc = 32'd0;
        for (int i = 0; i < 5; i++)
            step();
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_instr", rsp_instr, 32'h00000013);
        chk("arst_rsp_pc", rsp_pc, 32'd0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_ready", 32'(req_ready), 32'd1);
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 4) != 0;
            if (($urandom % 10) < 7)
                req_pc = {28'($urandom % DEPTH), 2'b00};
            else
                req_pc = $urandom_range(0, 63);
            rsp_ready = ($urandom % 4) != 0;
            flush = ($urandom % 40) == 0;
            prog_we = ($urandom % 10) == 0;
            prog_addr = 4'($urandom);
            prog_wdata = $urandom;
            step();
        end
        flush = 1'b0;
        prog_we = 1'b0;
        rsp_ready = 1'b1;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
